// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: five-phase RV32 control FSM with memory handshakes, illegal/timeout trap and retire counter
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ctrl_word,
  input  logic             branch_cond,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);
  localparam logic [2:0] FETCH = 3'b000;
  localparam logic [2:0] DECODE = 3'b001;
  localparam logic [2:0] EXEC = 3'b010;
  localparam logic [2:0] MEM = 3'b011;
  localparam logic [2:0] WB = 3'b100;
  localparam logic [2:0] TRAP = 3'b111;
  localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  logic [2:0] st, nxt;
  logic [7:0] ctrl_q;
  logic [TW-1:0] tcnt;
  logic [CNT_W-1:0] cnt;
  logic busy, rdy, tout, br;
  logic unused_ok;
  assign unused_ok = ^{ctrl_q[2], ctrl_q[0]};
  always_comb begin
    busy = st == FETCH || st == MEM;
    rdy = st == FETCH ? imem_ready : dmem_ready;
    // the wait that would be the (MEM_TIMEOUT+1)-th is never granted
    tout = MEM_TIMEOUT != 0 && busy && !rdy && tcnt == TW'(MEM_TIMEOUT - 1);
    nxt = TRAP;
    case (st)
      FETCH:   nxt = tout ? TRAP : imem_ready ? DECODE : FETCH;
      DECODE:  nxt = ctrl_word == 8'h00 ? TRAP : EXEC;
      EXEC:    nxt = ctrl_q[5:4] == 2'b01 ? FETCH : ctrl_q[5:4] == 2'b11 ? WB :
                     (ctrl_q[7] || ctrl_q[3]) ? MEM : WB;
      MEM:     nxt = tout ? TRAP : !dmem_ready ? MEM : ctrl_q[7] ? WB : FETCH;
      WB:      nxt = FETCH;
      default: nxt = TRAP;
    endcase
  end
  always_comb begin
    imem_req = !rst && st == FETCH;
    ir_we = imem_req && imem_ready;
    dmem_req = !rst && st == MEM;
    dmem_we = dmem_req && ctrl_q[3];
    rf_we = !rst && st == WB && ctrl_q[1];
    wb_sel = (!rst && st == WB) ? ctrl_q[7:6] : 2'b00;
    br = !rst && st == EXEC && ctrl_q[5:4] == 2'b01;
    pc_we = br || (dmem_req && dmem_ready && !ctrl_q[7]) || (!rst && st == WB);
    pc_sel = br && branch_cond;
    trap = !rst && st == TRAP;
    state = rst ? FETCH : st;
    instret = rst ? '0 : cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= FETCH;
      ctrl_q <= 8'h00;
      cnt <= '0;
      tcnt <= '0;
    end else begin
      st <= nxt;
      if (st == DECODE) ctrl_q <= ctrl_word;
      cnt <= cnt + CNT_W'(pc_we);
      tcnt <= (busy && !rdy) ? tcnt + TW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: table-driven cycle vectors plus hand sequences for trap, timeout and mid-instruction reset
module tb_multicycle_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] ctrl_word = 8'h00;
  logic branch_cond = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap;
  logic [1:0] wb_sel;
  logic [2:0] state;
  logic [31:0] instret;
  logic [9:0] outs;
  int checks = 0, errors = 0;
  typedef struct {
    logic rst;
    logic [7:0] cw;
    logic bc, ir, dr;
    logic [2:0] st;
    logic [9:0] outs;
    logic [31:0] ret;
  } vec_t;
  vec_t v[$];
  multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ctrl_word(ctrl_word), .branch_cond(branch_cond),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we),
    .pc_sel(pc_sel), .trap(trap), .state(state), .instret(instret)
  );
  assign outs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel, trap};
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic [7:0] c, input logic b, input logic i, input logic d,
                     input logic [2:0] s, input logic [9:0] o, input logic [31:0] n);
    vec_t e;
    e.rst = r; e.cw = c; e.bc = b; e.ir = i; e.dr = d; e.st = s; e.outs = o; e.ret = n;
    v.push_back(e);
  endtask
  task automatic step(input logic r, input logic [7:0] c, input logic b, input logic i, input logic d);
    @(negedge clk);
    rst = r; ctrl_word = c; branch_cond = b; imem_ready = i; dmem_ready = d;
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk3(input string nm, input logic [2:0] s, input logic [9:0] o, input logic [31:0] n);
    chk({nm, " state"}, 32'(state), 32'(s));
    chk({nm, " outs"}, 32'(outs), 32'(o));
    chk({nm, " instret"}, instret, n);
  endtask
  initial begin
    // ALU 22
    add(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 3'd0, 10'b0000000000, 32'd0);
    add(1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 3'd0, 10'b1100000000, 32'd0);
    add(1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 3'd1, 10'b0000000000, 32'd0);
    add(1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 3'd2, 10'b0000000000, 32'd0);
    add(1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 3'd4, 10'b0000100100, 32'd0);
    // branch 10, taken
    add(1'b0, 8'h10, 1'b1, 1'b1, 1'b1, 3'd0, 10'b1100000000, 32'd1);
    add(1'b0, 8'h10, 1'b1, 1'b1, 1'b1, 3'd1, 10'b0000000000, 32'd1);
    add(1'b0, 8'h10, 1'b1, 1'b1, 1'b1, 3'd2, 10'b0000000110, 32'd1);
    // load C4 with three wait cycles
    add(1'b0, 8'hC4, 1'b0, 1'b1, 1'b1, 3'd0, 10'b1100000000, 32'd2);
    add(1'b0, 8'hC4, 1'b0, 1'b1, 1'b1, 3'd1, 10'b0000000000, 32'd2);
    add(1'b0, 8'hC4, 1'b0, 1'b1, 1'b0, 3'd2, 10'b0000000000, 32'd2);
    add(1'b0, 8'hC4, 1'b0, 1'b1, 1'b0, 3'd3, 10'b0010000000, 32'd2);
    add(1'b0, 8'hC4, 1'b0, 1'b1, 1'b0, 3'd3, 10'b0010000000, 32'd2);
    add(1'b0, 8'hC4, 1'b0, 1'b1, 1'b0, 3'd3, 10'b0010000000, 32'd2);
    add(1'b0, 8'hC4, 1'b0, 1'b1, 1'b1, 3'd3, 10'b0010000000, 32'd2);
    add(1'b0, 8'hC4, 1'b0, 1'b1, 1'b1, 3'd4, 10'b0000011100, 32'd2);
    // store 08
    add(1'b0, 8'h08, 1'b0, 1'b1, 1'b1, 3'd0, 10'b1100000000, 32'd3);
    add(1'b0, 8'h08, 1'b0, 1'b1, 1'b1, 3'd1, 10'b0000000000, 32'd3);
    add(1'b0, 8'h08, 1'b0, 1'b1, 1'b1, 3'd2, 10'b0000000000, 32'd3);
    add(1'b0, 8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 10'b0011000100, 32'd3);
    // upper-immediate B8 after one fetch wait: read/write bits ignored
    add(1'b0, 8'hB8, 1'b1, 1'b0, 1'b1, 3'd0, 10'b1000000000, 32'd4);
    add(1'b0, 8'hB8, 1'b0, 1'b1, 1'b1, 3'd0, 10'b1100000000, 32'd4);
    add(1'b0, 8'hB8, 1'b0, 1'b1, 1'b1, 3'd1, 10'b0000000000, 32'd4);
    add(1'b0, 8'hB8, 1'b0, 1'b1, 1'b1, 3'd2, 10'b0000000000, 32'd4);
    add(1'b0, 8'hB8, 1'b0, 1'b1, 1'b1, 3'd4, 10'b0000010100, 32'd4);
    // illegal word
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 10'b1100000000, 32'd5);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 10'b0000000000, 32'd5);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 10'b0000000001, 32'd5);
    repeat (2) @(posedge clk);
    foreach (v[i]) begin
      step(v[i].rst, v[i].cw, v[i].bc, v[i].ir, v[i].dr);
      chk3($sformatf("row%0d", i), v[i].st, v[i].outs, v[i].ret);
    end
    // trap is sticky regardless of inputs
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h22, 1'b1, 1'b1, 1'b1);
      chk3($sformatf("hold%0d", i), 3'd7, 10'b0000000001, 32'd5);
    end
    step(1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
    chk3("trap_rst", 3'd0, 10'b0000000000, 32'd0);
    // fetch timeout with MEM_TIMEOUT=4
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
      chk3($sformatf("itout%0d", i), 3'd0, 10'b1000000000, 32'd0);
    end
    step(1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
    chk3("itout_trap", 3'd7, 10'b0000000001, 32'd0);
    // ready on the 4th wait cycle is still accepted
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
      chk3($sformatf("ilate%0d", i), 3'd0, 10'b1000000000, 32'd0);
    end
    step(1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
    chk3("ilate_acc", 3'd0, 10'b1100000000, 32'd0);
    step(1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
    chk3("ilate_dec", 3'd1, 10'b0000000000, 32'd0);
    step(1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
    chk3("ilate_exec", 3'd2, 10'b0000000000, 32'd0);
    // reset during WB suppresses the strobes and the retire
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    chk3("wb_rst", 3'd0, 10'b0000000000, 32'd0);
    step(1'b0, 8'h08, 1'b0, 1'b1, 1'b0);
    chk3("wb_rst_after", 3'd0, 10'b1100000000, 32'd0);
    step(1'b0, 8'h08, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h08, 1'b0, 1'b1, 1'b0);
    // store data-memory timeout
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h08, 1'b0, 1'b1, 1'b0);
      chk3($sformatf("dtout%0d", i), 3'd3, 10'b0011000000, 32'd0);
    end
    step(1'b0, 8'h08, 1'b0, 1'b1, 1'b1);
    chk3("dtout_trap", 3'd7, 10'b0000000001, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RV32 core. It steps each instruction through fetch, decode, execute, memory and writeback. It consumes the 8-bit control word produced by the opcode decoder and turns it into per-cycle strobes for the PC, IR, register file and data memory. It handles the ready handshakes of the instruction and data memories, detects illegal opcodes and memory timeouts, and counts retired instructions.

## Interface
Parameters:
- MEM_TIMEOUT, 15: max cycles a memory request may wait for ready; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ctrl_word  in  8  decoder word {dmemread, dmemtoreg, aluop[1:0], dmemwrite, alusrc, regwrite, imm}, bit 7 first.
- branch_cond  in  1  ALU branch-condition result, valid in EXEC.
- imem_ready  in  1  instruction memory has data this cycle.
- dmem_ready  in  1  data memory completes access this cycle.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  IR load strobe.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write qualifier, valid with dmem_req.
- rf_we  out  1  register file write strobe.
- wb_sel  out  2  writeback source, = ctrl_q[7:6] in WB, else 0.
- pc_we  out  1  PC update strobe.
- pc_sel  out  1  0 = PC+4, 1 = branch target; valid with pc_we.
- trap  out  1  sticky fault flag.
- state  out  3  current state code.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=111. Codes 101 and 110 are unreachable and go to TRAP.
- Outputs are decoded combinationally from state, ctrl_q and the ready inputs. While rst=1, all outputs read 0.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_we=1 in the same cycle, then go to DECODE.
- DECODE:
  - ctrl_q <= ctrl_word.
  - If ctrl_word==8'h00 (illegal), go to TRAP; otherwise go to EXEC.
- EXEC, class taken from ctrl_q:
  - Branch (aluop=01): pc_we=1, pc_sel=branch_cond, retire, go to FETCH.
  - Upper-immediate (aluop=11): go to WB. Bits 7 and 3 are ignored, so no memory access.
  - Otherwise, if dmemread or dmemwrite: go to MEM.
  - Otherwise: go to WB.
- MEM:
  - dmem_req=1, dmem_we=ctrl_q[3].
  - On dmem_ready=1: a load (bit 7) goes to WB. A store does pc_we=1, pc_sel=0, retires, and goes to FETCH.
- WB:
  - rf_we=ctrl_q[1], wb_sel=ctrl_q[7:6], pc_we=1, pc_sel=0.
  - Retire, then go to FETCH.
- TRAP:
  - trap=1; all strobes and requests are 0.
  - The block stays in TRAP until rst.
- Retire means instret <= instret+1, wrapping modulo 2^CNT_W.
- Timeout counter:
  - Cleared on every entry to FETCH or MEM.
  - Increments each cycle in FETCH/MEM while the matching ready=0.
  - If the counter equals MEM_TIMEOUT-1 and ready=0, go to TRAP next. Ready is therefore accepted up to and including the MEM_TIMEOUT-th wait cycle.
- Ready inputs are ignored outside their request state.

## Timing
- Reset values: state=FETCH, ctrl_q=0, instret=0, timeout counter=0, trap=0.
- imem_req rises in the first cycle after rst falls.
- Latency with zero-wait memories, FETCH to next FETCH:
  - Branch: 3 cycles.
  - ALU / immediate / upper-immediate: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle on imem_ready or dmem_ready adds exactly 1 cycle.
- Ready in the same cycle the request is first asserted completes that cycle (zero-wait).
- pc_we, ir_we and rf_we are single-cycle pulses per instruction.
- rst mid-instruction, including in TRAP: the next state is FETCH, and no strobe fires in the reset cycle.
- instret increments in the same edge as the pc_we pulse.

## Test plan
- Reset, then ALU word 8'h22 with imem_ready=1 and dmem_ready=1 held: states 000→001→010→100→000; rf_we=1 and pc_we=1 in WB; instret=1 after 4 cycles.
- Branch word 8'h10 with branch_cond=1: pc_we=1 and pc_sel=1 in EXEC; 3-cycle instruction; rf_we and dmem_req never asserted.
- Load word 8'hC4 with dmem_ready low for 3 cycles: MEM lasts 4 cycles; WB has wb_sel=2'b11 and rf_we=0; instret increments once.
- Store word 8'h08 with dmem_ready=1: dmem_we=1 in MEM; pc_we=1 in MEM; no WB state; instret+1.
- ctrl_word=8'h00: TRAP reached after DECODE; trap=1 held for 20 cycles with all strobes 0; rst then gives state=000, trap=0, instret=0.
- imem_ready held 0 with MEM_TIMEOUT=4: TRAP entered after the 4th FETCH cycle. Repeat with ready raised on the 4th cycle: no trap, DECODE follows.
